// File: rtl/pos_cell_port_arbiter_if.sv
// Requester-side bus of the cell position RAM arbiter: force-evaluation read
// port and motion-update write-back port.
interface pos_cell_port_arbiter_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_addr_out;
    logic                  rd_oob;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, rd_addr_out, rd_oob, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, rd_addr_out, rd_oob, wr_gnt
    );
endinterface

// File: rtl/pos_cell_port_arbiter.sv
// Sequencer/arbiter for the single-port cell position RAM (2-cycle read latency, word 0 = count).
// Optional macro POS_ARB_ROUND_ROBIN_EN: round-robin contention instead of write-wins priority.
module pos_cell_port_arbiter #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pos_cell_port_arbiter_if.slave bus,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {
        INIT_RD   = 2'd0,
        INIT_WAIT = 2'd1,
        SERVE     = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [1:0]            WAIT_LAST = 2'd2;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [1:0]            wait_cnt_r;
    logic                  rd_gnt_s;
    logic                  wr_gnt_s;
    logic                  init_done_r;
    logic [ADDR_WIDTH-1:0] particle_count_r;
    logic [ADDR_WIDTH-1:0] mem_address_r;
    logic [DATA_WIDTH-1:0] mem_data_r;
    logic                  mem_rden_r;
    logic                  mem_wren_r;
    logic [2:0]            pipe_vld_r;
    logic [2:0]            pipe_oob_r;
    logic [ADDR_WIDTH-1:0] pipe_addr_r [3];
`ifdef POS_ARB_ROUND_ROBIN_EN
    logic                  last_wr_r;
`endif

    // Counts above the RAM capacity are clamped to the last valid particle index.
    function automatic logic [ADDR_WIDTH-1:0] sat_count(input logic [ADDR_WIDTH-1:0] raw);
        if (raw > MAX_IDX) begin
            return MAX_IDX;
        end else begin
            return raw;
        end
    endfunction

    // State register and init wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= INIT_RD;
            wait_cnt_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == INIT_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end else begin
                wait_cnt_r <= 2'd0;
            end
        end
    end

    // Next state and single-port grant decision.
    always_comb begin
        state_nxt_s = state_r;
        rd_gnt_s    = 1'b0;
        wr_gnt_s    = 1'b0;
        case (state_r)
            INIT_RD: begin
                state_nxt_s = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = SERVE;
                end else begin
                    state_nxt_s = INIT_WAIT;
                end
            end
            SERVE: begin
                if (rst) begin
                    rd_gnt_s = 1'b0;
                    wr_gnt_s = 1'b0;
                end else if (bus.rd_req && bus.wr_req) begin
`ifdef POS_ARB_ROUND_ROBIN_EN
                    if (last_wr_r) begin
                        rd_gnt_s = 1'b1;
                    end else begin
                        wr_gnt_s = 1'b1;
                    end
`else
                    wr_gnt_s = 1'b1;
`endif
                end else if (bus.rd_req) begin
                    rd_gnt_s = 1'b1;
                end else if (bus.wr_req) begin
                    wr_gnt_s = 1'b1;
                end else begin
                    rd_gnt_s = 1'b0;
                    wr_gnt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = INIT_RD;
            end
        endcase
    end

`ifdef POS_ARB_ROUND_ROBIN_EN
    // Remembers which side won last; starts as "write" so read wins first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_r <= 1'b1;
        end else if (rd_gnt_s) begin
            last_wr_r <= 1'b0;
        end else if (wr_gnt_s) begin
            last_wr_r <= 1'b1;
        end else begin
            last_wr_r <= last_wr_r;
        end
    end
`endif

    // Registered RAM command: count fetch during init, granted access while serving.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_address_r <= {ADDR_WIDTH{1'b0}};
            mem_data_r    <= {DATA_WIDTH{1'b0}};
            mem_rden_r    <= 1'b0;
            mem_wren_r    <= 1'b0;
        end else begin
            case (state_r)
                INIT_RD: begin
                    mem_address_r <= {ADDR_WIDTH{1'b0}};
                    mem_rden_r    <= 1'b1;
                    mem_wren_r    <= 1'b0;
                end
                INIT_WAIT: begin
                    mem_rden_r <= 1'b0;
                    mem_wren_r <= 1'b0;
                end
                SERVE: begin
                    if (rd_gnt_s) begin
                        mem_address_r <= bus.rd_addr;
                        mem_rden_r    <= 1'b1;
                        mem_wren_r    <= 1'b0;
                    end else if (wr_gnt_s) begin
                        mem_address_r <= bus.wr_addr;
                        mem_data_r    <= bus.wr_data;
                        mem_rden_r    <= 1'b0;
                        mem_wren_r    <= 1'b1;
                    end else begin
                        mem_rden_r <= 1'b0;
                        mem_wren_r <= 1'b0;
                    end
                end
                default: begin
                    mem_rden_r <= 1'b0;
                    mem_wren_r <= 1'b0;
                end
            endcase
        end
    end

    // Particle count: loaded from RAM word 0 at end of init, then shadows writes to word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            particle_count_r <= {ADDR_WIDTH{1'b0}};
            init_done_r      <= 1'b0;
        end else if ((state_r == INIT_WAIT) && (wait_cnt_r == WAIT_LAST)) begin
            particle_count_r <= sat_count(mem_q[ADDR_WIDTH-1:0]);
            init_done_r      <= 1'b1;
        end else if (wr_gnt_s && (bus.wr_addr == {ADDR_WIDTH{1'b0}})) begin
            particle_count_r <= sat_count(bus.wr_data[ADDR_WIDTH-1:0]);
        end else begin
            particle_count_r <= particle_count_r;
        end
    end

    // Read-tracking pipe; the range check is frozen at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r <= 3'b000;
            pipe_oob_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                pipe_addr_r[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            pipe_vld_r     <= {pipe_vld_r[1:0], rd_gnt_s};
            pipe_oob_r     <= {pipe_oob_r[1:0], rd_gnt_s && (bus.rd_addr > particle_count_r)};
            pipe_addr_r[0] <= rd_gnt_s ? bus.rd_addr : {ADDR_WIDTH{1'b0}};
            pipe_addr_r[1] <= pipe_addr_r[0];
            pipe_addr_r[2] <= pipe_addr_r[1];
        end
    end

    assign bus.rd_gnt      = rd_gnt_s;
    assign bus.wr_gnt      = wr_gnt_s;
    assign bus.rd_valid    = pipe_vld_r[2];
    assign bus.rd_oob      = pipe_oob_r[2];
    assign bus.rd_addr_out = pipe_addr_r[2];
    // RAM q arrives unregistered in the return cycle; out-of-range reads are masked to zero.
    assign bus.rd_data     = (pipe_vld_r[2] && !pipe_oob_r[2]) ? mem_q : {DATA_WIDTH{1'b0}};
    assign init_done       = init_done_r;
    assign particle_count  = particle_count_r;
    assign mem_address     = mem_address_r;
    assign mem_data        = mem_data_r;
    assign mem_rden        = mem_rden_r;
    assign mem_wren        = mem_wren_r;

endmodule

// Property checker for the arbiter: port exclusivity and grant legality.
module pos_cell_port_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic init_done,
    input logic rd_req,
    input logic rd_gnt,
    input logic wr_req,
    input logic wr_gnt,
    input logic mem_rden,
    input logic mem_wren
);
    a_mem_excl:   assert property (@(posedge clk) disable iff (rst) !(mem_rden && mem_wren));
    a_one_gnt:    assert property (@(posedge clk) disable iff (rst) !(rd_gnt && wr_gnt));
    a_rd_gnt_ok:  assert property (@(posedge clk) disable iff (rst) rd_gnt |-> (rd_req && init_done));
    a_wr_gnt_ok:  assert property (@(posedge clk) disable iff (rst) wr_gnt |-> (wr_req && init_done));
endmodule

// File: tb/tb_pos_cell_port_arbiter.sv
// Randomized bench for pos_cell_port_arbiter: shadow-memory scoreboard with a RAM model.
module tb_pos_cell_port_arbiter;
    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic [AW-1:0] particle_count;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic          mem_rden;
    logic          mem_wren;

    always #5 clk = ~clk;

    pos_cell_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pos_cell_port_arbiter #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .init_done(init_done),
        .particle_count(particle_count), .mem_address(mem_address), .mem_data(mem_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    pos_cell_port_arbiter_chk u_chk (
        .clk(clk), .rst(rst), .init_done(init_done),
        .rd_req(bus.rd_req), .rd_gnt(bus.rd_gnt), .wr_req(bus.wr_req), .wr_gnt(bus.wr_gnt),
        .mem_rden(mem_rden), .mem_wren(mem_wren)
    );

    // Reference state: what the RAM should hold and what each read should return.
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            oob;
    } rd_exp_t;

    logic [DW-1:0] ref_mem [PN];
    rd_exp_t       exp_q [$];
    int            ref_count;
    bit            serving;
    bit            last_wr;
    bit            exp_rg_last;
    bit            exp_wg_last;
    bit            got_rg;
    bit            got_wg;
    int            cyc;
    int            n_vec;
    int            n_err;
    logic          load_ram;

    // Single-port RAM model with two cycles of read latency.
    logic [DW-1:0] ram [PN];
    logic [DW-1:0] ram_q1;
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < PN; i++) ram[i] <= ref_mem[i];
        end else if (mem_wren && (int'(mem_address) < PN)) begin
            ram[mem_address] <= mem_data;
        end
        if (mem_rden) ram_q1 <= (int'(mem_address) < PN) ? ram[mem_address] : {DW{1'b0}};
        mem_q <= ram_q1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sat_cnt(input logic [DW-1:0] w);
        int v;
        v = int'(w[7:0]);
        return (v > PN - 1) ? PN - 1 : v;
    endfunction

    // One serving cycle: predict grants, check outputs, then update the reference.
    task automatic cycle();
        bit      erg;
        bit      ewg;
        rd_exp_t e;
        @(negedge clk);
        erg = 1'b0;
        ewg = 1'b0;
        if (serving) begin
            if (bus.rd_req && bus.wr_req) begin
`ifdef POS_ARB_ROUND_ROBIN_EN
                erg = last_wr;
                ewg = !last_wr;
`else
                ewg = 1'b1;
`endif
            end else begin
                erg = bus.rd_req;
                ewg = bus.wr_req;
            end
        end
        got_rg = bus.rd_gnt;
        got_wg = bus.wr_gnt;
        check_val("rd_gnt", 128'(bus.rd_gnt), 128'(erg));
        check_val("wr_gnt", 128'(bus.wr_gnt), 128'(ewg));
        check_val("mem_excl", 128'(mem_rden & mem_wren), 128'd0);
        check_val("init_done", 128'(init_done), 128'(serving));
        check_val("particle_count", 128'(particle_count), 128'(ref_count));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check_val("rd_valid", 128'(bus.rd_valid), 128'd1);
            check_val("rd_data", 128'(bus.rd_data), 128'(e.data));
            check_val("rd_addr_out", 128'(bus.rd_addr_out), 128'(e.addr));
            check_val("rd_oob", 128'(bus.rd_oob), 128'(e.oob));
        end else begin
            check_val("rd_valid_idle", 128'(bus.rd_valid), 128'd0);
        end
        if (erg) begin
            e.due  = cyc + 3;
            e.addr = bus.rd_addr;
            e.oob  = int'(bus.rd_addr) > ref_count;
            if (e.oob) e.data = {DW{1'b0}};
            else       e.data = ref_mem[bus.rd_addr];
            exp_q.push_back(e);
        end
        if (ewg) begin
            ref_mem[bus.wr_addr] = bus.wr_data;
            if (bus.wr_addr == 8'd0) ref_count = sat_cnt(bus.wr_data);
        end
        if (erg)      last_wr = 1'b0;
        else if (ewg) last_wr = 1'b1;
        exp_rg_last = erg;
        exp_wg_last = ewg;
        @(posedge clk);
        #1;
    endtask

    // Hold reset n cycles, then walk the count fetch with both requests held high.
    task automatic reset_and_init(input int n);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check_val("rst_rd_valid", 128'(bus.rd_valid), 128'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        serving = 1'b0;
        last_wr = 1'b1;
        exp_rg_last = 1'b0;
        exp_wg_last = 1'b0;
        bus.rd_req = 1'b1;  bus.rd_addr = 8'd1;
        bus.wr_req = 1'b1;  bus.wr_addr = 8'd1;  bus.wr_data = {DW{1'b1}};
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check_val("init_rd_gnt", 128'(bus.rd_gnt), 128'd0);
            check_val("init_wr_gnt", 128'(bus.wr_gnt), 128'd0);
            check_val("init_done_seq", 128'(init_done), 128'(k == 4));
            check_val("init_rd_valid", 128'(bus.rd_valid), 128'd0);
            if (k == 0) begin
                check_val("rst_mem_rden", 128'(mem_rden), 128'd0);
                check_val("rst_mem_wren", 128'(mem_wren), 128'd0);
                check_val("rst_mem_addr", 128'(mem_address), 128'd0);
                check_val("rst_count", 128'(particle_count), 128'd0);
                check_val("rst_rd_data", 128'(bus.rd_data), 128'd0);
                check_val("rst_addr_out", 128'(bus.rd_addr_out), 128'd0);
                check_val("rst_oob", 128'(bus.rd_oob), 128'd0);
            end
            if (k == 1) begin
                check_val("init_mem_rden", 128'(mem_rden), 128'd1);
                check_val("init_mem_addr", 128'(mem_address), 128'd0);
            end
            if (k == 4) check_val("init_count", 128'(particle_count), 128'(sat_cnt(ref_mem[0])));
            @(posedge clk);
            #1;
            if (k == 3) begin
                bus.rd_req = 1'b0;
                bus.wr_req = 1'b0;
            end
        end
        serving   = 1'b1;
        ref_count = sat_cnt(ref_mem[0]);
    endtask

    task automatic read_one(input logic [AW-1:0] a);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        cycle();
        bus.rd_req  = 1'b0;
    endtask

    initial begin
        int  rc;
        int  wc;
        bit  first_rg;
        bus.rd_req = 1'b0;  bus.rd_addr = 8'd0;
        bus.wr_req = 1'b0;  bus.wr_addr = 8'd0;  bus.wr_data = {DW{1'b0}};
        for (int i = 0; i < PN; i++) ref_mem[i] = {$urandom, $urandom, $urandom};
        ref_mem[0] = 96'd5;
        load_ram = 1'b1;
        reset_and_init(3);
        load_ram = 1'b0;

        // Single read, then back-to-back reads 1..4.
        read_one(8'd3);
        repeat (4) cycle();
        bus.rd_req = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            bus.rd_addr = AW'(a);
            cycle();
        end
        bus.rd_req = 1'b0;
        repeat (4) cycle();

        // Range boundaries around count = 5.
        read_one(8'd9);
        read_one(8'd0);
        read_one(8'd5);
        read_one(8'd6);
        repeat (4) cycle();

        // Count update via write to word 0, then a now-legal read of 6.
        bus.wr_req = 1'b1;  bus.wr_addr = 8'd0;  bus.wr_data = 96'd7;
        cycle();
        bus.wr_req = 1'b0;
        read_one(8'd6);
        repeat (4) cycle();

        // Read-before-write and write-before-read on the same word.
        read_one(8'd2);
        bus.wr_req = 1'b1;  bus.wr_addr = 8'd2;  bus.wr_data = {$urandom, $urandom, $urandom};
        cycle();
        bus.wr_req = 1'b0;
        read_one(8'd2);
        repeat (4) cycle();

        // Reset right after a read grant drops that read.
        read_one(8'd4);
        reset_and_init(1);

        // Contention from a fresh reset.
        bus.rd_req = 1'b1;  bus.rd_addr = 8'd1;
        bus.wr_req = 1'b1;  bus.wr_addr = 8'd10;  bus.wr_data = {$urandom, $urandom, $urandom};
        rc = 0;
        wc = 0;
        first_rg = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 0) first_rg = got_rg;
            rc += int'(got_rg);
            wc += int'(got_wg);
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
`ifdef POS_ARB_ROUND_ROBIN_EN
        check_val("arb_rd_cnt", 128'(rc), 128'd3);
        check_val("arb_wr_cnt", 128'(wc), 128'd3);
        check_val("arb_first_rd", 128'(first_rg), 128'd1);
`else
        check_val("arb_rd_cnt", 128'(rc), 128'd0);
        check_val("arb_wr_cnt", 128'(wc), 128'd6);
        check_val("arb_first_rd", 128'(first_rg), 128'd0);
`endif
        repeat (4) cycle();

        // Random traffic; requests are held until the reference says they were granted.
        exp_rg_last = 1'b0;
        exp_wg_last = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.rd_req || exp_rg_last) begin
                bus.rd_req = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 99) < 80) bus.rd_addr = AW'($urandom_range(0, ref_count + 2));
                else                            bus.rd_addr = AW'($urandom_range(0, 255));
            end
            if (!bus.wr_req || exp_wg_last) begin
                bus.wr_req  = ($urandom_range(0, 99) < 50);
                bus.wr_addr = ($urandom_range(0, 31) == 0) ? 8'd0 : AW'($urandom_range(1, PN - 1));
                bus.wr_data = {$urandom, $urandom, $urandom};
            end
            cycle();
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        repeat (5) cycle();
        check_val("drain_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
